// File: rtl/alu_frame_driver_pkg.sv
// rtl/alu_frame_driver_pkg.sv - shared constants and types for the serial ALU frame driver
package alu_frame_driver_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;

    // Slot order of one 4-clock ALU frame
    typedef enum logic [1:0] {
        PH_OP  = 2'd0,
        PH_A   = 2'd1,
        PH_B   = 2'd2,
        PH_OUT = 2'd3
    } phase_t;

endpackage

// File: rtl/alu_frame_driver_if.sv
// rtl/alu_frame_driver_if.sv - request/response handshake bundle of the frame driver
interface alu_frame_driver_if;
    import alu_frame_driver_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - two-entry first-in first-out response buffer
module alu_rsp_fifo
    import alu_frame_driver_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    input  logic [DATA_W-1:0] s_tdata_i,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    assign s_tready_o = (count_q != 2'(FIFO_DEPTH));
    assign m_tvalid_o = (count_q != 2'd0);
    assign m_tdata_o  = m_tvalid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
    assign push       = s_tvalid_i && s_tready_o;
    assign pop        = m_tvalid_o && m_tready_i;

    // Storage, pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_tdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_frame_driver.sv
// rtl/alu_frame_driver.sv - frames requests onto the 4-phase serial ALU bus and buffers results
module alu_frame_driver
    import alu_frame_driver_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    alu_frame_driver_if.slave bus,
    output logic [DATA_W-1:0] alu_in_o,
    input  logic [DATA_W-1:0] alu_out_i,
    output logic              alu_rst_n_o
);

    phase_t            phase_q;
    logic              frame_vld_q;   // current frame carries an accepted request
    logic              res_due_q;     // alu_out holds a wanted result during this phase 0
    logic              push_q;        // captured result waiting to enter the FIFO
    logic [DATA_W-1:0] res_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        inflight_q;
    logic [1:0]        fifo_count;
    logic              fifo_in_ready;
    logic              fifo_out_valid;
    logic [DATA_W-1:0] fifo_out_data;
    logic [2:0]        occupancy;
    logic              req_ready_int;
    logic              accept;
    logic              push_fire;

    // Occupancy counts no credit for a pop in the same cycle, so the FIFO can never overflow
    assign occupancy     = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign req_ready_int = !reset_i && (phase_q == PH_OUT) && (occupancy < 3'd2);
    assign accept        = bus.req_valid && req_ready_int;
    assign push_fire     = push_q && fifo_in_ready;

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_valid = fifo_out_valid && !reset_i;
    assign bus.rsp_data  = reset_i ? '0 : fifo_out_data;
    assign alu_rst_n_o   = ~reset_i;

    // Free-running slot counter, restarting at PH_OP together with the ALU
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            phase_q <= PH_OP;
        end else begin
            phase_q <= phase_t'(phase_q + 2'd1);
        end
    end

    // Frame ownership, result sampling one frame later and capture into push stage
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            frame_vld_q <= 1'b0;
            res_due_q   <= 1'b0;
            push_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            push_q <= 1'b0;
            if (phase_q == PH_OUT) begin
                frame_vld_q <= accept;
                res_due_q   <= frame_vld_q;
            end
            if ((phase_q == PH_OP) && res_due_q) begin
                res_q     <= alu_out_i;
                push_q    <= 1'b1;
                res_due_q <= 1'b0;
            end
        end
    end

    // Operand latch, loaded only on an accepted request
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
        end
    end

    // Frames between acceptance and their push into the FIFO
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            inflight_q <= 2'd0;
        end else begin
            case ({accept, push_fire})
                2'b10:   inflight_q <= inflight_q + 2'd1;
                2'b01:   inflight_q <= inflight_q - 2'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Serial operand bus: op, A, B, then idle slot; all zero in empty frames
    always_comb begin
        alu_in_o = '0;
        if (!reset_i && frame_vld_q) begin
            case (phase_q)
                PH_OP:   alu_in_o = {4'h0, op_q};
                PH_A:    alu_in_o = a_q;
                PH_B:    alu_in_o = b_q;
                default: alu_in_o = '0;
            endcase
        end
    end

    alu_rsp_fifo u_rsp_fifo (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .s_tvalid_i (push_q),
        .s_tready_o (fifo_in_ready),
        .s_tdata_i  (res_q),
        .m_tvalid_o (fifo_out_valid),
        .m_tready_i (bus.rsp_ready),
        .m_tdata_o  (fifo_out_data),
        .count_o    (fifo_count)
    );

endmodule

// File: doc/alu_frame_driver.md
ALU_FRAME_DRIVER -- requirements
Module: alu_frame_driver

Interface
REQ-001 clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  1  requester has an operation available.
REQ-004 req_ready  out  1  driver accepts the operation this cycle.
REQ-005 req_op  in  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, others reserved.
REQ-006 req_a / req_b  in  8 each  operands A and B.
REQ-007 alu_in  out  8  shared serial operand bus to the 4-phase serial ALU.
REQ-008 alu_out  in  8  registered result from the serial ALU.
REQ-009 alu_rst_n  out  1  active-low reset to the serial ALU, equal to ~reset combinationally.
REQ-010 rsp_valid  out  1  response FIFO head is valid.
REQ-011 rsp_ready  in  1  consumer accepts the head this cycle.
REQ-012 rsp_data  out  8  result at the FIFO head.

Function
REQ-013 A free-running 2-bit phase counter SHALL go 0->1->2->3->0 every clock, mirroring the ALU slot counter (0 op, 1 A, 2 B, 3 out-load).
REQ-014 A request SHALL be accepted (req_valid && req_ready) only on a phase-3 cycle.
REQ-015 req_ready SHALL be 1 iff phase==3 and occupancy<2, where occupancy = frames in flight + FIFO entries at cycle start, with no credit for a same-cycle pop.
REQ-016 After acceptance at phase 3 the following frame SHALL drive alu_in = {4'h0, op} in phase 0, A in phase 1, B in phase 2 and 8'h00 in phase 3, using operands latched at acceptance.
REQ-017 In frames with no accepted request, alu_in SHALL be 8'h00 in all phases, and that frame's result SHALL be discarded.
REQ-018 An accepted frame's result SHALL be sampled from alu_out at the end of phase 0 of the next frame and pushed into the FIFO.
REQ-019 Latency SHALL be fixed: rsp_valid rises 6 clocks after the accepting edge when the FIFO is empty.
REQ-020 With rsp_ready held at 1 and req_valid held at 1, throughput SHALL be one operation per 4 clocks.
REQ-021 The FIFO SHALL be 2 entries and first-in first-out; a simultaneous push and pop SHALL keep the count unchanged.
REQ-022 REQ-015 SHALL prevent any push while the FIFO is full.
REQ-023 rsp_data SHALL stay stable while rsp_valid && !rsp_ready.
REQ-024 The driver SHALL NOT compute or check results; reserved opcodes SHALL be forwarded unchanged, and their ALU result (0) SHALL be returned.
REQ-025 8-bit wrap SHALL be inherited from the ALU; no carry or borrow is reported.

Reset
REQ-026 While reset=1: phase=0, req_ready=0, rsp_valid=0, rsp_data=8'h00, alu_in=8'h00, FIFO empty, in-flight cleared, alu_rst_n=0.
REQ-027 A reset mid-frame SHALL drop the in-flight frame and all FIFO contents without producing a response.
REQ-028 The first clock after reset deasserts SHALL be phase 0, aligned with the ALU's counter restart.

Structure
REQ-029 A shared package SHALL hold the opcode constants (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3), the phase constants (PH_OP, PH_A, PH_B, PH_OUT) and the FIFO depth (2).
REQ-030 The response buffer SHALL be a sub-module alu_rsp_fifo (8-bit wide, 2 entries, valid/ready on both sides, count output).
REQ-031 The phase counter, in-flight tracking, operand latch and alu_in mux SHALL reside in alu_frame_driver.

Verification
REQ-032 Directed scenarios, each run against the serial ALU instance:
- OR op=3, A=1, B=2 -> alu_in sequence 03,01,02,00; rsp_data=03 six clocks after accept.
- AND op=2, A=1, B=2 -> 00; ADD 0xFF+0x01 -> 00; SUB 0x00-0x01 -> FF.
- Four back-to-back ADDs (1+1, 2+2, 3+3, 4+4), rsp_ready=1 -> responses 02,04,06,08 in order, spaced 4 clocks apart.
- rsp_ready=0 with a stream of requests -> exactly 2 accepted, req_ready then 0; after rsp_ready=1, both drain in order, none lost.
- Reserved op=9, A=5, B=6 -> rsp_data=00.
- reset pulsed during phase 2 of an accepted frame -> no response; FIFO empty; next request completes correctly with phase alignment intact.
